mdio_controller: RTL and testbench

- MAC/station-side MDIO management controller: generates MDC and serializes Clause-22 management frames onto MDIO_OUT/MDIO_OE.
- Sits directly upstream of Recep_MDIO and drives its MDC, MDIO_OE and MDIO_OUT inputs.
- Consumes the receiver's MDIO_IN during reads, deserializes 16 read-data bits and presents them on RD_DATA with a one-cycle DATA_RDY strobe.

---
 rtl/mdio_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_mdio_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdio_controller.sv
// mdio_controller
//   Station-side Clause-22 MDIO master. Generates MDC, serializes the
//   management frame on MDIO_OUT/MDIO_OE and captures 16 read-data bits
//   from MDIO_IN during read frames.
//
//   State table:
//     IDLE      | MDC low, bus released; accepts MDIO_START
//     PREAMBLE  | drives PRE_LEN '1' bits
//     HEADER    | drives T_DATA[31:16] (ST, OP, PHYAD, REGAD, TA)
//     WR_DATA   | drives T_DATA[15:0]
//     RD_DATA_S | bus released, samples MDIO_IN at each MDC fall
//     DONE      | one cycle; read data published with DATA_RDY
//
//   Ports:
//     clk         system clock
//     rst         asynchronous active-low reset
//     MDIO_START  frame request (honoured in IDLE only)
//     T_DATA      {ST, OP, PHYAD, REGAD, TA, write data}
//     MDIO_IN     serial read data from the PHY side
//     MDC         management clock, period 2*DIV clk
//     MDIO_OE     1 while the controller drives MDIO_OUT
//     MDIO_OUT    serial frame data, MSB first
//     RD_DATA     last completed read data
//     DATA_RDY    one-clk strobe when RD_DATA is updated
//     BUSY        frame in progress
module mdio_controller #(
  parameter int DIV     = 2,
  parameter int PRE_LEN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  localparam int PH_W = $clog2(2 * DIV);
  // last clk of the MDC low phase, and last clk of the whole bit
  localparam logic [PH_W-1:0] PH_LOW_END = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_BIT_END = PH_W'(2 * DIV - 1);
  localparam logic [5:0]      PRE_LAST   = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [5:0]        bit_q, bit_d;
  logic [31:0]       sr_q, sr_d;
  logic              is_rd_q, is_rd_d;
  logic              mdc_q, mdc_d;
  logic              oe_q, oe_d;
  logic              out_q, out_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  assign bit_end = (phase_q == PH_BIT_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      is_rd_q   <= 1'b0;
      mdc_q     <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
      rd_data_q <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      is_rd_q   <= is_rd_d;
      mdc_q     <= mdc_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
      rd_data_q <= rd_data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    is_rd_d   = is_rd_q;
    mdc_d     = mdc_q;
    oe_d      = oe_q;
    out_d     = out_q;
    rd_data_d = rd_data_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;

    // MDC generation shared by every frame state: low for DIV clks, then
    // high for DIV clks. The bit-end edge is also the MDC falling edge,
    // which is the only place the data/OE outputs are allowed to move.
    if (state_q != ST_IDLE && state_q != ST_DONE) begin
      if (bit_end) begin
        phase_d = '0;
        mdc_d   = 1'b0;
      end else begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_LOW_END) mdc_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        mdc_d = 1'b0;
        oe_d  = 1'b0;
        if (MDIO_START) begin
          sr_d    = T_DATA;
          is_rd_d = (T_DATA[29:28] == 2'b10);
          busy_d  = 1'b1;
          oe_d    = 1'b1;
          phase_d = '0;
          bit_d   = '0;
          if (PRE_LEN > 0) begin
            state_d = ST_PREAMBLE;
            out_d   = 1'b1;
          end else begin
            state_d = ST_HEADER;
            out_d   = T_DATA[31];
          end
        end
      end

      ST_PREAMBLE: begin
        if (bit_end) begin
          if (bit_q == PRE_LAST) begin
            state_d = ST_HEADER;
            bit_d   = '0;
            out_d   = sr_q[31];
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      // sr_q[31] is always the bit currently on the wire, so the next one
      // to present is sr_q[30] before the shift takes effect.
      ST_HEADER: begin
        if (bit_end) begin
          sr_d = {sr_q[30:0], 1'b0};
          if (bit_q == 6'd15) begin
            bit_d = '0;
            if (is_rd_q) begin
              state_d = ST_RD_DATA;
              oe_d    = 1'b0;
              out_d   = 1'b0;
            end else begin
              state_d = ST_WR_DATA;
              out_d   = sr_q[30];
            end
          end else begin
            bit_d = bit_q + 1'b1;
            out_d = sr_q[30];
          end
        end
      end

      ST_WR_DATA: begin
        if (bit_end) begin
          sr_d = {sr_q[30:0], 1'b0};
          if (bit_q == 6'd15) begin
            state_d = ST_DONE;
            bit_d   = '0;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
            out_d = sr_q[30];
          end
        end
      end

      // The header bits have been shifted out, so the low half of the
      // shift register is reused to collect the read data.
      ST_RD_DATA: begin
        if (bit_end) begin
          sr_d = {sr_q[30:0], MDIO_IN};
          if (bit_q == 6'd15) begin
            state_d   = ST_DONE;
            bit_d     = '0;
            busy_d    = 1'b0;
            rd_data_d = {sr_q[14:0], MDIO_IN};
            rdy_d     = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        mdc_d   = 1'b0;
        oe_d    = 1'b0;
        out_d   = 1'b0;
        phase_d = '0;
        bit_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        mdc_d   = 1'b0;
        oe_d    = 1'b0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign MDC      = mdc_q;
  assign MDIO_OE  = oe_q;
  assign MDIO_OUT = out_q;
  assign RD_DATA  = rd_data_q;
  assign DATA_RDY = rdy_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller. Instance 0: DIV=2, no preamble.
// Instance 1: DIV=1, 32-bit preamble. The reference model derives the
// expected per-clk MDC/OE/OUT waveform from the frame word by arithmetic
// on the clk index and plays the PHY role on MDIO_IN during read bits.
module tb_mdio_controller;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic        start   [2];
  logic [31:0] tdata   [2];
  logic        mdio_in [2];
  logic        mdc     [2];
  logic        oe      [2];
  logic        mout    [2];
  logic [15:0] rd      [2];
  logic        rdy     [2];
  logic        busy    [2];

  logic [15:0] exp_rd  [2];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mdio_controller #(.DIV(2), .PRE_LEN(0)) u_dut0 (
    .clk(clk), .rst(rst_n[0]), .MDIO_START(start[0]), .T_DATA(tdata[0]),
    .MDIO_IN(mdio_in[0]), .MDC(mdc[0]), .MDIO_OE(oe[0]), .MDIO_OUT(mout[0]),
    .RD_DATA(rd[0]), .DATA_RDY(rdy[0]), .BUSY(busy[0])
  );

  mdio_controller #(.DIV(1), .PRE_LEN(32)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .MDIO_START(start[1]), .T_DATA(tdata[1]),
    .MDIO_IN(mdio_in[1]), .MDC(mdc[1]), .MDIO_OE(oe[1]), .MDIO_OUT(mout[1]),
    .RD_DATA(rd[1]), .DATA_RDY(rdy[1]), .BUSY(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle. Requests one frame,
  // follows it clk by clk and checks DONE and the following IDLE cycle.
  task automatic run_frame(input int w, input logic [31:0] td, input logic [15:0] phy,
                           input bit hold, input bit poke);
    int   div, pre, total, bad, oe_cnt, b;
    bit   is_rd;
    logic e_mdc, e_oe, e_out;
    div   = (w == 0) ? 2 : 1;
    pre   = (w == 0) ? 0 : 32;
    is_rd = (td[29:28] == 2'b10);
    total = (pre + 32) * 2 * div;
    check("idle_busy", 32'(busy[w]), 32'd0);
    tdata[w] = td;
    start[w] = 1'b1;
    @(negedge clk);
    if (!hold) start[w] = 1'b0;
    tdata[w] = $urandom;
    bad    = 0;
    oe_cnt = 0;
    for (int k = 0; k < total; k++) begin
      b     = k / (2 * div);
      e_mdc = ((k % (2 * div)) >= div);
      if (b < pre) begin
        e_oe = 1'b1; e_out = 1'b1;
      end else if (b < pre + 16 || !is_rd) begin
        e_oe = 1'b1; e_out = td[31 - (b - pre)];
      end else begin
        e_oe = 1'b0; e_out = 1'b0;
      end
      if ({mdc[w], oe[w], mout[w], busy[w], rdy[w]} !== {e_mdc, e_oe, e_out, 1'b1, 1'b0})
        bad++;
      if (oe[w] === 1'b1) oe_cnt++;
      if (is_rd && b >= pre + 16) mdio_in[w] = phy[15 - (b - pre - 16)];
      else                        mdio_in[w] = 1'($urandom);
      if (poke) start[w] = (k == 10 || k == 40);
      @(negedge clk);
    end
    check("wave_bad_cycles", 32'(bad), 32'd0);
    check("oe_cycles", 32'(oe_cnt), 32'((pre + 16 + (is_rd ? 0 : 16)) * 2 * div));
    if (is_rd) exp_rd[w] = phy;
    check("done_busy", 32'(busy[w]), 32'd0);
    check("done_oe",   32'(oe[w]),   32'd0);
    check("done_mdc",  32'(mdc[w]),  32'd0);
    check("done_rdy",  32'(rdy[w]),  32'(is_rd));
    check("done_rd",   32'(rd[w]),   32'(exp_rd[w]));
    @(negedge clk);
    check("post_rdy",  32'(rdy[w]),  32'd0);
    check("post_busy", 32'(busy[w]), 32'd0);
    check("post_rd",   32'(rd[w]),   32'(exp_rd[w]));
  endtask

  initial begin
    logic [31:0] td;
    logic [15:0] phy;
    int          w;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; tdata[i] = '0; mdio_in[i] = 1'b0; exp_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_mdc",  32'(mdc[i]),  32'd0);
      check("rst_oe",   32'(oe[i]),   32'd0);
      check("rst_out",  32'(mout[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_rdy",  32'(rdy[i]),  32'd0);
      check("rst_rd",   32'(rd[i]),   32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    run_frame(0, 32'h5A3C_BEEF, 16'h0000, 1'b0, 1'b0);
    run_frame(0, 32'h6ABC_0000, 16'hBEEF, 1'b0, 1'b0);
    run_frame(0, 32'h5123_4567, 16'h0000, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("reject_no_frame", 32'({busy[0], oe[0]}), 32'd0);
    end

    run_frame(1, 32'h5A3C_BEEF, 16'h0000, 1'b0, 1'b0);
    run_frame(1, 32'h6923_4567, 16'hC3A5, 1'b0, 1'b0);

    run_frame(0, 32'h5555_1111, 16'h0000, 1'b1, 1'b0);
    run_frame(0, 32'h6A02_0000, 16'h1357, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      w   = int'($urandom_range(1, 0));
      td  = $urandom;
      if ($urandom_range(1, 0) == 1) td[29:28] = 2'b10;
      phy = 16'($urandom);
      run_frame(w, td, phy, 1'b0, 1'b0);
    end

    run_frame(0, 32'h6A02_0000, 16'hA5A5, 1'b0, 1'b0);
    tdata[0] = 32'h5A3C_BEEF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (22) @(negedge clk);
    check("mid_busy", 32'({busy[0], oe[0], mdc[0]}), 32'd7);
    #2 rst_n[0] = 1'b0;
    #1;
    exp_rd[0] = '0;
    check("abort_mdc",  32'(mdc[0]),  32'd0);
    check("abort_oe",   32'(oe[0]),   32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_rd",   32'(rd[0]),   32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", 32'({rdy[0], busy[0], oe[0]}), 32'd0);
    end
    run_frame(0, 32'h6ABC_0000, 16'h0F0F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
